lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Load/store initiator between the CPU memory stage and the data memory port (address/storeData/byteEnable/storeValid out; loadData/loadDataValid/storeComplete in).
- Accepts one memory request at a time from the pipeline and checks alignment.
- Generates byte lanes and replicated store data, and drives a single storeValid pulse per store.
- Waits for completion, then returns sign- or zero-extended load data or a fault to the pipeline.

Parameters:
- TIMEOUT_CYCLES, 16, cycles to wait for loadDataValid/storeComplete before a bus fault (used only with LSU_TIMEOUT_EN).

Ports:
- clock input 1 system clock
- reset input 1 asynchronous, active-low reset
- reqValid input 1 pipeline request valid
- reqReady output 1 unit idle, request accepted this cycle
- reqWrite input 1 1=store, 0=load
- reqSize input 2 0=byte, 1=half, 2=word, 3=illegal
- reqUnsigned input 1 zero-extend load (LBU/LHU)
- reqAddress input 32 byte address
- reqStoreData input 32 store data, right-aligned
- respValid output 1 one-cycle completion pulse
- respData output 32 extended load data (0 for stores/faults)
- respFault output 2 0=none, 1=misaligned/illegal size, 2=timeout
- address output 32 word address {reqAddress[31:2],2'b00}
- storeData output 32 lane-replicated store data
- byteEnable output 4 active byte lanes
- storeValid output 1 store request level
- loadData input 32 memory read word
- loadDataValid input 1 read data valid
- storeComplete input 1 one-cycle store done pulse

Behaviour:
- Reset (reset low, async): state IDLE; all outputs 0 except reqReady=1; storeValid drops immediately, including mid-store. Any in-flight request is discarded with no response.
- All memory-side outputs and response outputs are registered.
- States: IDLE, LOAD, STORE, RESP.
- IDLE:
  - reqReady=1.
  - On reqValid, latch address, size, unsigned flag and data.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or reqSize=3: go to RESP with fault=1; no memory access, byteEnable stays 0.
  - Otherwise go to LOAD or STORE.
- reqReady=0 in every state except IDLE.
- LOAD:
  - address held stable.
  - On loadDataValid=1, capture and extract, then go to RESP.
  - Extraction: word >> (addr[1:0]*8); byte/half sign-extended unless unsigned.
- STORE:
  - storeValid=1, byteEnable and storeData held stable.
  - Byte lanes: byte = 4'b0001<<addr[1:0] with data {4{d[7:0]}}; half = 4'b0011<<{addr[1],0} with data {2{d[15:0]}}; word = 4'b1111 with data d.
  - On storeComplete=1, go to RESP.
- RESP:
  - respValid=1 for exactly one cycle; storeValid=0 and byteEnable=0; then IDLE.
- storeValid is guaranteed low for at least 2 cycles between stores (RESP and IDLE), so the edge-triggered memory never misses or repeats a store.
- Latency, accept cycle = 0:
  - Load with loadDataValid already high: respValid at cycle 2.
  - Store with storeComplete on cycle 2: respValid at cycle 3.
  - Fault: respValid at cycle 1.
- A storeComplete or loadDataValid arriving in the wrong state is ignored.
- A new request is never accepted in the cycle respValid is high.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - Counter clears on entry to LOAD/STORE and increments each cycle waiting.
  - Reaching TIMEOUT_CYCLES-1 without completion moves to RESP with fault=2, respData=0, and drops storeValid.
- Undefined: no counter; the unit waits indefinitely and fault=2 is never produced.

Decomposition:
- Shared package lsu_pkg:
  - size enum (SIZE_BYTE, SIZE_HALF, SIZE_WORD).
  - state enum (IDLE, LOAD, STORE, RESP).
  - fault enum (FAULT_NONE, FAULT_ALIGN, FAULT_TIMEOUT).
- One combinational sub-module lsu_lane_align: byteEnable, storeData replication and load extraction/extension from size, offset and unsigned flag.

Test Plan:
- SB addr 0x00000103, data 0x000000AB -> address 0x00000100, byteEnable 4'b1000, storeData 0xABABABAB, single storeValid episode, respValid 1 cycle after storeComplete, fault 0.
- LH addr 0x202 with loadData 0x8001_1234 -> respData 0xFFFF8001; LHU same -> 0x00008001; LB addr 0x201 -> 0x00000012.
- LW addr 0x06 -> respValid at cycle 1, fault 1, no storeValid, byteEnable 0; reqSize=3 -> fault 1.
- Back-to-back SW 0x10 then SW 0x14, storeComplete 1 cycle after storeValid -> storeValid low ≥2 cycles between stores, exactly two storeComplete pulses consumed.
- reset low during STORE -> storeValid 0 immediately, reqReady 1 after release, no respValid.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, loadDataValid held 0 -> respValid with fault 2 sixteen cycles after entering LOAD, then IDLE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store memory port: access sizes, FSM states,
// fault codes and the alignment rule used when a request is accepted.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'd0,
        FAULT_ALIGN   = 2'd1,
        FAULT_TIMEOUT = 2'd2
    } fault_e;

    // Size code 3 has no meaning and is reported like a misaligned access.
    function automatic logic access_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = |offset;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the memory port: byte enables and replicated store
// data for a store, and shift plus sign/zero extension for a load word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic        zero_ext_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_word_i,
    output logic [3:0]  byte_enable_o,
    output logic [31:0] store_data_o,
    output logic [31:0] load_data_o
);

    logic [31:0] load_shifted;
    logic        byte_sign;
    logic        half_sign;

    assign load_shifted = load_word_i >> {offset_i, 3'b000};
    assign byte_sign    = ~zero_ext_i & load_shifted[7];
    assign half_sign    = ~zero_ext_i & load_shifted[15];

    // Decode lanes and extension from the access size; illegal sizes select nothing.
    always_comb begin
        byte_enable_o = 4'b0000;
        store_data_o  = '0;
        load_data_o   = '0;
        case (size_i)
            SIZE_BYTE: begin
                byte_enable_o = 4'b0001 << offset_i;
                store_data_o  = {4{store_data_i[7:0]}};
                load_data_o   = {{24{byte_sign}}, load_shifted[7:0]};
            end
            SIZE_HALF: begin
                byte_enable_o = 4'b0011 << {offset_i[1], 1'b0};
                store_data_o  = {2{store_data_i[15:0]}};
                load_data_o   = {{16{half_sign}}, load_shifted[15:0]};
            end
            SIZE_WORD: begin
                byte_enable_o = 4'b1111;
                store_data_o  = store_data_i;
                load_data_o   = load_shifted;
            end
            default: begin
                byte_enable_o = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator between the memory pipeline stage and the data memory
// port. One request in flight at a time; alignment is checked on accept.
// Optional build macro LSU_TIMEOUT_EN adds a completion timeout that reports
// fault code 2 after TIMEOUT_CYCLES waiting cycles.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [1:0]  reqSize,
    input  logic        reqUnsigned,
    input  logic [31:0] reqAddress,
    input  logic [31:0] reqStoreData,
    output logic        respValid,
    output logic [31:0] respData,
    output logic [1:0]  respFault,
    output logic [31:0] address,
    output logic [31:0] storeData,
    output logic [3:0]  byteEnable,
    output logic        storeValid,
    input  logic [31:0] loadData,
    input  logic        loadDataValid,
    input  logic        storeComplete
);

    state_e      state_q;
    logic [1:0]  size_q;
    logic [1:0]  offset_q;
    logic        zero_ext_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic [31:0] resp_data_q;
    fault_e      resp_fault_q;
    logic [31:0] address_q;
    logic [31:0] store_data_q;
    logic [3:0]  byte_enable_q;
    logic        store_valid_q;

    logic [1:0]  lane_size;
    logic [1:0]  lane_offset;
    logic        lane_zext;
    logic [3:0]  lane_byte_enable;
    logic [31:0] lane_store_data;
    logic [31:0] lane_load_data;
    logic        req_misaligned;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] wait_cnt_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    assign req_misaligned = access_misaligned(reqSize, reqAddress[1:0]);

    // Lanes come from the live request while idle (to register store lanes on
    // accept) and from the latched request while a load waits for its data.
    always_comb begin
        lane_size   = size_q;
        lane_offset = offset_q;
        lane_zext   = zero_ext_q;
        if (state_q == IDLE) begin
            lane_size   = reqSize;
            lane_offset = reqAddress[1:0];
            lane_zext   = reqUnsigned;
        end
    end

    lsu_lane_align u_lane_align (
        .size_i        (lane_size),
        .offset_i      (lane_offset),
        .zero_ext_i    (lane_zext),
        .store_data_i  (reqStoreData),
        .load_word_i   (loadData),
        .byte_enable_o (lane_byte_enable),
        .store_data_o  (lane_store_data),
        .load_data_o   (lane_load_data)
    );

    // Request sequencing; every memory-side and response output is a register here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            size_q        <= 2'b00;
            offset_q      <= 2'b00;
            zero_ext_q    <= 1'b0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_data_q   <= '0;
            resp_fault_q  <= FAULT_NONE;
            address_q     <= '0;
            store_data_q  <= '0;
            byte_enable_q <= 4'b0000;
            store_valid_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (reqValid) begin
                        size_q      <= reqSize;
                        offset_q    <= reqAddress[1:0];
                        zero_ext_q  <= reqUnsigned;
                        address_q   <= {reqAddress[31:2], 2'b00};
                        req_ready_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
                        wait_cnt_q  <= '0;
`endif
                        if (req_misaligned) begin
                            // Rejected without touching memory.
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_fault_q <= FAULT_ALIGN;
                            resp_data_q  <= '0;
                        end else begin
                            byte_enable_q <= lane_byte_enable;
                            if (reqWrite) begin
                                state_q       <= STORE;
                                store_data_q  <= lane_store_data;
                                store_valid_q <= 1'b1;
                            end else begin
                                state_q <= LOAD;
                            end
                        end
                    end
                end
                LOAD: begin
                    if (loadDataValid) begin
                        state_q       <= RESP;
                        resp_valid_q  <= 1'b1;
                        resp_fault_q  <= FAULT_NONE;
                        resp_data_q   <= lane_load_data;
                        byte_enable_q <= 4'b0000;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wait_cnt_q == CntLast) begin
                        state_q       <= RESP;
                        resp_valid_q  <= 1'b1;
                        resp_fault_q  <= FAULT_TIMEOUT;
                        resp_data_q   <= '0;
                        byte_enable_q <= 4'b0000;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CntW'(1);
                    end
`endif
                end
                STORE: begin
                    if (storeComplete) begin
                        state_q       <= RESP;
                        resp_valid_q  <= 1'b1;
                        resp_fault_q  <= FAULT_NONE;
                        resp_data_q   <= '0;
                        byte_enable_q <= 4'b0000;
                        store_valid_q <= 1'b0;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wait_cnt_q == CntLast) begin
                        state_q       <= RESP;
                        resp_valid_q  <= 1'b1;
                        resp_fault_q  <= FAULT_TIMEOUT;
                        resp_data_q   <= '0;
                        byte_enable_q <= 4'b0000;
                        store_valid_q <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CntW'(1);
                    end
`endif
                end
                RESP: begin
                    // One-cycle response; ready returns only afterwards.
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    resp_data_q  <= '0;
                    resp_fault_q <= FAULT_NONE;
                    req_ready_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign reqReady   = req_ready_q;
    assign respValid  = resp_valid_q;
    assign respData   = resp_data_q;
    assign respFault  = resp_fault_q;
    assign address    = address_q;
    assign storeData  = store_data_q;
    assign byteEnable = byte_enable_q;
    assign storeValid = store_valid_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: directed scenarios plus randomized
// requests compared against an arithmetic reference model.
module tb_lsu_mem_port;

    localparam int TIMEOUT = 16;
    localparam int BUDGET  = 60;

    logic        clock;
    logic        reset;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [1:0]  reqSize;
    logic        reqUnsigned;
    logic [31:0] reqAddress;
    logic [31:0] reqStoreData;
    logic        respValid;
    logic [31:0] respData;
    logic [1:0]  respFault;
    logic [31:0] address;
    logic [31:0] storeData;
    logic [3:0]  byteEnable;
    logic        storeValid;
    logic [31:0] loadData;
    logic        loadDataValid;
    logic        storeComplete;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations from the most recent transaction.
    int          obs_resp_cycle;
    int          obs_sc_cycle;
    int          obs_sv_rises;
    logic [31:0] obs_resp_data;
    logic [1:0]  obs_resp_fault;
    logic [31:0] obs_addr;
    logic [31:0] obs_store_addr;
    logic [3:0]  obs_store_be;
    logic [31:0] obs_store_data;
    logic [3:0]  obs_fault_be;
    logic        obs_sv_in_resp;
    logic        obs_ready_in_resp;
    logic        obs_resp_after;
    logic        obs_ready_after;

    // Free-running monitor of store episodes and response pulses.
    int   mon_rises   = 0;
    int   mon_low     = 0;
    int   mon_min_gap = 1000;
    int   mon_resp    = 0;
    logic mon_prev    = 1'b0;

    lsu_mem_port #(
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .reqValid      (reqValid),
        .reqReady      (reqReady),
        .reqWrite      (reqWrite),
        .reqSize       (reqSize),
        .reqUnsigned   (reqUnsigned),
        .reqAddress    (reqAddress),
        .reqStoreData  (reqStoreData),
        .respValid     (respValid),
        .respData      (respData),
        .respFault     (respFault),
        .address       (address),
        .storeData     (storeData),
        .byteEnable    (byteEnable),
        .storeValid    (storeValid),
        .loadData      (loadData),
        .loadDataValid (loadDataValid),
        .storeComplete (storeComplete)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (storeValid === 1'b1 && mon_prev !== 1'b1) begin
            if (mon_rises > 0 && mon_low < mon_min_gap) mon_min_gap = mon_low;
            mon_rises = mon_rises + 1;
        end
        if (storeValid === 1'b1) mon_low = 0;
        else mon_low = mon_low + 1;
        mon_prev = storeValid;
        if (respValid === 1'b1) mon_resp = mon_resp + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    // Issue one request and play the memory; cycle 1 is the cycle after accept.
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rword, input int delay);
        int   c;
        int   first_sv;
        int   wait_c;
        bit   done;
        logic prev_sv;
        obs_resp_cycle = -1; obs_sc_cycle = -1; obs_sv_rises = 0;
        obs_resp_data = '0; obs_resp_fault = '0; obs_addr = '0;
        obs_store_addr = '0; obs_store_be = '0; obs_store_data = '0; obs_fault_be = '0;
        obs_sv_in_resp = 1'bx; obs_ready_in_resp = 1'bx;
        obs_resp_after = 1'bx; obs_ready_after = 1'bx;
        wait_c = 0;
        while (reqReady !== 1'b1 && wait_c < 20) begin
            @(posedge clock); #1;
            wait_c++;
        end
        n_checks++;
        if (reqReady !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_wait: reqReady=%b required 1", reqReady);
        end
        reqValid = 1'b1; reqWrite = wr; reqSize = sz; reqUnsigned = uns;
        reqAddress = addr; reqStoreData = wdata; loadData = rword;
        loadDataValid = !wr && delay == 0;
        storeComplete = 1'b0;
        first_sv = -1; done = 0; prev_sv = 1'b0;
        for (c = 1; c <= BUDGET && !done; c++) begin
            @(posedge clock); #1;
            reqValid = 1'b0;
            if (c == 1) obs_addr = address;
            if (storeComplete) obs_sc_cycle = c - 1;
            if (storeValid === 1'b1 && prev_sv !== 1'b1) begin
                obs_sv_rises++;
                if (first_sv < 0) first_sv = c;
                obs_store_addr = address; obs_store_be = byteEnable; obs_store_data = storeData;
            end
            prev_sv = storeValid;
            obs_fault_be = obs_fault_be | byteEnable;
            if (respValid === 1'b1) begin
                obs_resp_cycle = c; obs_resp_data = respData; obs_resp_fault = respFault;
                obs_sv_in_resp = storeValid; obs_ready_in_resp = reqReady;
                done = 1;
            end
            loadDataValid = !wr && !done && (c >= 1 + delay);
            // Loads also see a stray storeComplete, which must be ignored.
            storeComplete = !done && ((wr && first_sv >= 0 && c == first_sv + delay) ||
                                      (!wr && c == 1));
        end
        loadDataValid = 1'b0; storeComplete = 1'b0;
        if (done) begin
            @(posedge clock); #1;
            obs_resp_after = respValid; obs_ready_after = reqReady;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #2 reset = 1'b0;
        #5;
        n_checks++;
        if (reqReady !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", reqReady); end
        n_checks++;
        if ({respValid, storeValid, byteEnable, respFault} !== 8'h00) begin
            n_fail++; $display("FAIL reset_ctrl: got %b required 0", {respValid, storeValid, byteEnable, respFault});
        end
        n_checks++;
        if ({address, storeData, respData} !== 96'h0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h/%h required 0", address, storeData, respData);
        end
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_store_byte;
        run_req(1'b1, 2'd0, 1'b0, 32'h0000_0103, 32'h0000_00AB, 32'h0, 1);
        n_checks++;
        if (obs_store_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL sb_address: got %h required 00000100", obs_store_addr); end
        n_checks++;
        if (obs_store_be !== 4'b1000) begin n_fail++; $display("FAIL sb_byteEnable: got %b required 1000", obs_store_be); end
        n_checks++;
        if (obs_store_data !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_storeData: got %h required abababab", obs_store_data); end
        n_checks++;
        if (obs_sv_rises !== 1) begin n_fail++; $display("FAIL sb_episodes: got %0d required 1", obs_sv_rises); end
        n_checks++;
        if (obs_resp_cycle !== 3 || obs_sc_cycle !== 2) begin
            n_fail++; $display("FAIL sb_latency: resp cycle %0d after complete %0d, required 3 after 2", obs_resp_cycle, obs_sc_cycle);
        end
        n_checks++;
        if (obs_resp_fault !== 2'd0 || obs_sv_in_resp !== 1'b0) begin
            n_fail++; $display("FAIL sb_resp: fault %0d storeValid %b required 0/0", obs_resp_fault, obs_sv_in_resp);
        end
    endtask

    task automatic test_loads;
        run_req(1'b0, 2'd1, 1'b0, 32'h0000_0202, 32'h0, 32'h8001_1234, 0);
        n_checks++;
        if (obs_resp_cycle !== 2 || obs_resp_data !== 32'hFFFF_8001) begin
            n_fail++; $display("FAIL lh: cycle %0d data %h required 2 ffff8001", obs_resp_cycle, obs_resp_data);
        end
        run_req(1'b0, 2'd1, 1'b1, 32'h0000_0202, 32'h0, 32'h8001_1234, 2);
        n_checks++;
        if (obs_resp_cycle !== 4 || obs_resp_data !== 32'h0000_8001) begin
            n_fail++; $display("FAIL lhu: cycle %0d data %h required 4 00008001", obs_resp_cycle, obs_resp_data);
        end
        run_req(1'b0, 2'd0, 1'b0, 32'h0000_0201, 32'h0, 32'h8001_1234, 1);
        n_checks++;
        if (obs_resp_data !== 32'h0000_0012 || obs_addr !== 32'h0000_0200) begin
            n_fail++; $display("FAIL lb: data %h address %h required 00000012 00000200", obs_resp_data, obs_addr);
        end
    endtask

    task automatic test_faults;
        run_req(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'h0, 32'hDEAD_BEEF, 0);
        n_checks++;
        if (obs_resp_cycle !== 1 || obs_resp_fault !== 2'd1 || obs_resp_data !== 32'h0) begin
            n_fail++; $display("FAIL lw_misaligned: cycle %0d fault %0d data %h required 1 1 0", obs_resp_cycle, obs_resp_fault, obs_resp_data);
        end
        n_checks++;
        if (obs_sv_rises !== 0 || obs_fault_be !== 4'b0000) begin
            n_fail++; $display("FAIL lw_misaligned_mem: episodes %0d byteEnable %b required 0 0000", obs_sv_rises, obs_fault_be);
        end
        run_req(1'b1, 2'd3, 1'b0, 32'h0000_0020, 32'h1234_5678, 32'h0, 1);
        n_checks++;
        if (obs_resp_cycle !== 1 || obs_resp_fault !== 2'd1 || obs_sv_rises !== 0) begin
            n_fail++; $display("FAIL size3: cycle %0d fault %0d episodes %0d required 1 1 0", obs_resp_cycle, obs_resp_fault, obs_sv_rises);
        end
    endtask

    task automatic test_back_to_back;
        int resp0;
        int rises0;
        resp0 = mon_resp; rises0 = mon_rises; mon_min_gap = 1000;
        run_req(1'b1, 2'd2, 1'b0, 32'h0000_0010, 32'h1111_2222, 32'h0, 1);
        n_checks++;
        if (obs_resp_fault !== 2'd0 || obs_store_be !== 4'hF) begin
            n_fail++; $display("FAIL b2b_first: fault %0d be %b required 0 1111", obs_resp_fault, obs_store_be);
        end
        run_req(1'b1, 2'd2, 1'b0, 32'h0000_0014, 32'h3333_4444, 32'h0, 1);
        n_checks++;
        if (obs_store_addr !== 32'h14 || obs_store_data !== 32'h3333_4444) begin
            n_fail++; $display("FAIL b2b_second: addr %h data %h required 14 33334444", obs_store_addr, obs_store_data);
        end
        n_checks++;
        if (mon_rises - rises0 !== 2 || mon_resp - resp0 !== 2) begin
            n_fail++; $display("FAIL b2b_count: stores %0d responses %0d required 2 2", mon_rises - rises0, mon_resp - resp0);
        end
        n_checks++;
        if (mon_min_gap < 2) begin n_fail++; $display("FAIL b2b_gap: low cycles %0d required >=2", mon_min_gap); end
    endtask

    task automatic test_reset_mid_store;
        int resp0;
        reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd2; reqUnsigned = 1'b0;
        reqAddress = 32'h0000_0040; reqStoreData = 32'h5A5A_0F0F; storeComplete = 1'b0;
        @(posedge clock); #1;
        reqValid = 1'b0;
        @(posedge clock); #1;
        n_checks++;
        if (storeValid !== 1'b1) begin n_fail++; $display("FAIL rst_store_started: storeValid %b required 1", storeValid); end
        resp0 = mon_resp;
        #3 reset = 1'b0;
        #1;
        n_checks++;
        if (storeValid !== 1'b0 || byteEnable !== 4'b0000 || reqReady !== 1'b1) begin
            n_fail++; $display("FAIL rst_async: storeValid %b be %b ready %b required 0 0000 1", storeValid, byteEnable, reqReady);
        end
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        n_checks++;
        if (mon_resp !== resp0 || reqReady !== 1'b1 || storeValid !== 1'b0) begin
            n_fail++; $display("FAIL rst_after: responses %0d ready %b storeValid %b required %0d 1 0", mon_resp, reqReady, storeValid, resp0);
        end
    endtask

    task automatic test_timeout;
`ifdef LSU_TIMEOUT_EN
        run_req(1'b0, 2'd2, 1'b0, 32'h0000_0080, 32'h0, 32'hCAFE_F00D, 1000);
        n_checks++;
        if (obs_resp_cycle !== 1 + TIMEOUT || obs_resp_fault !== 2'd2 || obs_resp_data !== 32'h0) begin
            n_fail++; $display("FAIL timeout: cycle %0d fault %0d data %h required %0d 2 0", obs_resp_cycle, obs_resp_fault, obs_resp_data, 1 + TIMEOUT);
        end
        n_checks++;
        if (obs_ready_after !== 1'b1) begin n_fail++; $display("FAIL timeout_idle: ready %b required 1", obs_ready_after); end
`else
        // Without the timeout the unit keeps waiting well past TIMEOUT cycles.
        run_req(1'b0, 2'd2, 1'b0, 32'h0000_0080, 32'h0, 32'hCAFE_F00D, 40);
        n_checks++;
        if (obs_resp_cycle !== 42 || obs_resp_fault !== 2'd0 || obs_resp_data !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL no_timeout: cycle %0d fault %0d data %h required 42 0 cafef00d", obs_resp_cycle, obs_resp_fault, obs_resp_data);
        end
`endif
    endtask

    task automatic test_random;
        logic        wr;
        logic        uns;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rword;
        logic [31:0] v;
        logic [31:0] exp_data;
        logic [31:0] exp_sdata;
        logic [3:0]  exp_be;
        int          nbytes;
        int          delay;
        bit          misal;
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            addr = $urandom; wdata = $urandom; rword = $urandom;
            nbytes = (sz == 2'd3) ? 1 : (1 << sz);
            if ($urandom_range(0, 2) != 0) addr = addr - (addr % nbytes);
            delay = wr ? int'($urandom_range(1, 3)) : int'($urandom_range(0, 3));
            misal = (sz == 2'd3) || (addr % nbytes) != 0;
            // Reference: plain arithmetic on the access rules.
            exp_data = 32'h0;
            if (!wr && !misal) begin
                v = rword >> (8 * (addr % 4));
                if (nbytes == 1) begin
                    v = v % 256;
                    if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
                end else if (nbytes == 2) begin
                    v = v % 65536;
                    if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
                end
                exp_data = v;
            end
            exp_be    = 4'(((1 << nbytes) - 1) << (addr % 4));
            exp_sdata = (nbytes == 1) ? (wdata % 256) * 32'h0101_0101 :
                        (nbytes == 2) ? (wdata % 65536) * 32'h0001_0001 : wdata;
            run_req(wr, sz, uns, addr, wdata, rword, delay);
            n_checks++;
            if (obs_resp_cycle !== (misal ? 1 : 2 + delay) || obs_resp_fault !== (misal ? 2'd1 : 2'd0)) begin
                n_fail++; $display("FAIL rnd%0d_resp: cycle %0d fault %0d required %0d %0d", i, obs_resp_cycle, obs_resp_fault, misal ? 1 : 2 + delay, misal ? 1 : 0);
            end
            n_checks++;
            if (obs_resp_data !== exp_data) begin n_fail++; $display("FAIL rnd%0d_data: got %h required %h", i, obs_resp_data, exp_data); end
            n_checks++;
            if (obs_addr !== (addr & 32'hFFFF_FFFC)) begin n_fail++; $display("FAIL rnd%0d_addr: got %h required %h", i, obs_addr, addr & 32'hFFFF_FFFC); end
            n_checks++;
            if (obs_sv_rises !== ((wr && !misal) ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_episodes: got %0d required %0d", i, obs_sv_rises, (wr && !misal) ? 1 : 0); end
            if (wr && !misal) begin
                n_checks++;
                if (obs_store_be !== exp_be || obs_store_data !== exp_sdata) begin
                    n_fail++; $display("FAIL rnd%0d_lanes: be %b data %h required %b %h", i, obs_store_be, obs_store_data, exp_be, exp_sdata);
                end
            end
            if (misal) begin
                n_checks++;
                if (obs_fault_be !== 4'b0000) begin n_fail++; $display("FAIL rnd%0d_fault_be: got %b required 0000", i, obs_fault_be); end
            end
            n_checks++;
            if (obs_sv_in_resp !== 1'b0 || obs_ready_in_resp !== 1'b0 || obs_resp_after !== 1'b0 || obs_ready_after !== 1'b1) begin
                n_fail++; $display("FAIL rnd%0d_handshake: sv %b ready %b next valid %b next ready %b required 0 0 0 1", i, obs_sv_in_resp, obs_ready_in_resp, obs_resp_after, obs_ready_after);
            end
        end
    endtask

    initial begin
        reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'd0; reqUnsigned = 1'b0;
        reqAddress = '0; reqStoreData = '0; loadData = '0;
        loadDataValid = 1'b0; storeComplete = 1'b0;
        test_reset();
        test_store_byte();
        test_loads();
        test_faults();
        test_back_to_back();
        test_reset_mid_store();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
